// File: rtl/serial_sub.sv
// serial_sub -- bit-serial unsigned subtractor, computes (A - B - bin) mod 2^WIDTH
// LSB first, one full-subtractor step per clock, with a single borrow flop
// carrying the borrow from one bit to the next.
//
// Handshake: start is sampled only while the block is idle (busy=0). The edge
// that samples start=1 captures a_in, b_in and bin, and busy rises after it.
// busy stays high through the RUN phase and the single done cycle. done is a
// one-cycle pulse marking diff/borr valid. diff/borr then hold until the next
// operation completes. start seen while busy is ignored.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request to begin an operation (idle only)
//   a_in      minuend, captured on the accepted start edge
//   b_in      subtrahend, captured on the accepted start edge
//   bin       borrow-in, captured on the accepted start edge
//   busy      high from the accepted start until the done cycle ends
//   done      one-cycle result-valid pulse
//   diff      registered difference
//   borr      registered final borrow-out (1 when A < B + bin)
//   dbg_state current FSM state (0=IDLE, 1=RUN, 2=DONE) for observation

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [CW-1:0]    cnt;
  logic             bor;

  logic             d_bit;
  logic             bor_nxt;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  always_comb begin
    d_bit   = a_sh[0] ^ b_sh[0] ^ bor;
    bor_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bor);
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      cnt   <= '0;
      bor   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      borr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            bor   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          // Result bits enter at the MSB so that after WIDTH shifts the
          // first (LSB) result bit has arrived at position 0.
          d_sh <= {d_bit, d_sh[WIDTH-1:1]};
          bor  <= bor_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Publish the final word directly, including the bit computed
            // on this edge, rather than waiting a cycle for d_sh.
            diff  <= {d_bit, d_sh[WIDTH-1:1]};
            borr  <= bor_nxt;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial N-bit subtractor that computes A − B − bin, LSB first, one bit per clock.
- Each bit is computed by a full-subtractor cell: d = a ^ b ^ bor; bor_next = (~a & b) | (~(a ^ b) & bor).
- A single borrow flip-flop carries the borrow between bits.
- Sits downstream of the operand source and upstream of any result consumer, using a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin; sampled only in IDLE
a_in  input  WIDTH  minuend; captured on the accepted start edge
b_in  input  WIDTH  subtrahend; captured on the accepted start edge
bin  input  1  borrow-in; captured on the accepted start edge
busy  output  1  high from the accepted start until the done cycle ends
done  output  1  one-cycle pulse when the result is valid
diff  output  WIDTH  registered difference (A − B − bin) mod 2^WIDTH
borr  output  1  registered final borrow-out (1 when A < B + bin)

Behaviour:
- One clock is used. Reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, diff=0, borr=0; internal shift registers, counter and borrow flop are cleared.
- States: IDLE → RUN → DONE → IDLE.
- IDLE:
  - If start=1 at an edge (E0): load a_sh=a_in, b_sh=b_in, bor=bin, cnt=0, then go to RUN. busy=1 after E0.
  - If start=0: stay in IDLE.
- RUN, each edge E1..EWIDTH:
  - Compute d and bor_next from a_sh[0], b_sh[0] and bor.
  - Shift a_sh and b_sh right by one.
  - Shift d into the MSB of the internal d_sh register.
  - Set bor=bor_next and cnt=cnt+1.
  - At the edge where cnt==WIDTH−1 (edge EWIDTH):
    - diff <= final d_sh, including the current bit.
    - borr <= bor_next.
    - Go to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - Next edge goes to IDLE; done=0, busy=0.
- Latency: result valid and done high in the cycle after edge EWIDTH, i.e. WIDTH+1 edges after start is sampled.
- Throughput: one operation per WIDTH+2 cycles. A start asserted in the DONE cycle is ignored; start is accepted only in IDLE.
- diff and borr are written only at edge EWIDTH. They hold their value through IDLE and throughout the next operation until that operation completes.
- start while in RUN or DONE is ignored. Changes on a_in, b_in or bin after E0 have no effect.
- start held continuously high restarts the block on every IDLE cycle.
- rst_n asserted mid-RUN aborts immediately: all outputs return to reset values and the partial result is discarded. After rst_n is released, the block waits in IDLE for a fresh start.
- Arithmetic is unsigned, modulo 2^WIDTH. borr equals the borrow of the full-width subtraction, matching the borrow out of a ripple chain of full subtractors.
- cnt is sized ceil(log2(WIDTH)) bits and never wraps inside RUN.

Test Plan:
1. WIDTH=8, a_in=0x5A, b_in=0x3C, bin=0, start pulse → done 9 edges after start sampled; diff=0x1E, borr=0; busy high for 9 cycles.
2. a_in=0x00, b_in=0x01, bin=0 → diff=0xFF, borr=1. Then a_in=0x0F, b_in=0x0F, bin=1 → diff=0xFF, borr=1. Then a_in=0x10, b_in=0x0F, bin=1 → diff=0x00, borr=0.
3. Start with a_in=0x80, b_in=0x01. Pulse start again at RUN cycle 3 with a_in=0xFF, and change b_in mid-run → ignored; diff=0x7F, borr=0; exactly one done pulse.
4. Deassert rst_n at RUN cycle 4 → busy, done, diff and borr go to 0 without waiting for a clock edge. Release rst_n, then start with a_in=0x03, b_in=0x05 → diff=0xFE, borr=1.
5. Hold start high for 30 cycles → back-to-back operations with one IDLE cycle between done and the next busy. diff/borr from the previous operation hold until each new completion.
6. WIDTH=4: exhaustive loop over all 512 combinations of a_in, b_in and bin → diff == (a−b−bin)&0xF and borr == (a < b+bin) every time.
